// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// The master modport is the issuing pipeline side; the slave modport is the unit.
interface riscv_muldiv_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic            flush_i;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
        input  ready_o, valid_o, result_o, rd_o
    );

    modport slave (
        input  valid_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
        output ready_o, valid_o, result_o, rd_o
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit. Multiplies use shift-add and
// divides use restoring radix-2, both on operand magnitudes with a final
// sign fix-up. Divide special cases and (optionally) multiplies finish in a
// single cycle.
module riscv_muldiv_unit #(
    parameter int unsigned XLEN     = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input logic                clk_i,
    input logic                rst_i,
    riscv_muldiv_unit_if.slave bus
);
    localparam int unsigned W2   = 2 * XLEN;
    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        tag_q;
    logic              neg_q;      // negate product or quotient
    logic              neg_rem_q;  // negate remainder (sign of dividend)
    logic [W2-1:0]     acc_q;
    logic [W2-1:0]     mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dsor_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;
    // Last delivered result, restored if the op completing in DONE is flushed.
    logic [XLEN-1:0]   res_prev_q;
    logic [4:0]        rd_prev_q;

    // Accept-time decode.
    logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic [W2-1:0]     fast_prod;

    // Per-iteration datapath.
    logic [W2-1:0]     mul_acc_nxt;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;
    logic              ge;
    logic [XLEN-1:0]   rem_nxt, quo_nxt, quo_fin, rem_fin, iter_res;
    logic              unused_div;

    // Sign-correct a magnitude product and pick the low or high half.
    function automatic logic [XLEN-1:0] mul_select(input logic [W2-1:0] mag,
                                                   input logic          neg,
                                                   input logic [1:0]    sel);
        logic [W2-1:0] p;
        p = neg ? -mag : mag;
        return (sel == 2'b00) ? p[XLEN-1:0] : p[W2-1:XLEN];
    endfunction

    // Operand signedness, magnitudes and single-cycle special results.
    always_comb begin
        is_div   = bus.op_i[2];
        a_sgn    = is_div ? !bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
        b_sgn    = is_div ? !bus.op_i[0] : !bus.op_i[1];
        a_neg    = a_sgn && bus.rs1_i[XLEN-1];
        b_neg    = b_sgn && bus.rs2_i[XLEN-1];
        a_mag    = a_neg ? -bus.rs1_i : bus.rs1_i;
        b_mag    = b_neg ? -bus.rs2_i : bus.rs2_i;
        div_zero = (bus.rs2_i == '0);
        div_ovf  = !bus.op_i[0] && (bus.rs1_i == MinNeg) && (bus.rs2_i == '1);
        special  = is_div && (div_zero || div_ovf);
        if (div_zero) begin
            special_res = bus.op_i[1] ? bus.rs1_i : '1;
        end else begin
            special_res = bus.op_i[1] ? '0 : bus.rs1_i;
        end
        fast_prod = W2'(a_mag) * W2'(b_mag);
    end

    // One shift-add step and one restoring-divide step, plus final fix-up.
    always_comb begin
        mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
        rem_sh      = {rem_q, quo_q[XLEN-1]};
        diff        = {1'b0, rem_sh} - {2'b00, dsor_q};
        ge          = !diff[XLEN+1];
        rem_nxt     = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nxt     = {quo_q[XLEN-2:0], ge};
        quo_fin     = neg_q ? -quo_nxt : quo_nxt;
        rem_fin     = neg_rem_q ? -rem_nxt : rem_nxt;
        if (op_q[2]) begin
            iter_res = op_q[1] ? rem_fin : quo_fin;
        end else begin
            iter_res = mul_select(mul_acc_nxt, neg_q, op_q[1:0]);
        end
        // Top bits are provably zero whenever they would be kept.
        unused_div = diff[XLEN] ^ rem_sh[XLEN];
    end

    assign bus.ready_o  = (state_q == StIdle);
    assign bus.valid_o  = (state_q == StDone) && !bus.flush_i;
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_out_q;

    // Control FSM with the iteration datapath and registered results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dsor_q     <= '0;
            result_q   <= '0;
            rd_out_q   <= '0;
            res_prev_q <= '0;
            rd_prev_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.valid_i && !bus.flush_i) begin
                        op_q      <= bus.op_i;
                        tag_q     <= bus.rd_i;
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (special || (FAST_MUL && !is_div)) begin
                            result_q   <= special ? special_res
                                                  : mul_select(fast_prod, a_neg ^ b_neg,
                                                               bus.op_i[1:0]);
                            rd_out_q   <= bus.rd_i;
                            res_prev_q <= result_q;
                            rd_prev_q  <= rd_out_q;
                            state_q    <= StDone;
                        end else begin
                            cnt_q    <= CntW'(XLEN);
                            acc_q    <= '0;
                            mcand_q  <= W2'(a_mag);
                            mplier_q <= b_mag;
                            rem_q    <= '0;
                            quo_q    <= a_mag;
                            dsor_q   <= b_mag;
                            state_q  <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q    <= mul_acc_nxt;
                        mcand_q  <= {mcand_q[W2-2:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
                        rem_q    <= rem_nxt;
                        quo_q    <= quo_nxt;
                        cnt_q    <= cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            result_q   <= iter_res;
                            rd_out_q   <= tag_q;
                            res_prev_q <= result_q;
                            rd_prev_q  <= rd_out_q;
                            state_q    <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (bus.flush_i) begin
                        result_q <= res_prev_q;
                        rd_out_q <= rd_prev_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
